// File: rtl/regfile_port_sched.sv
// regfile_port_sched: per-cycle arbiter sharing the 1W/2R register file
// port between the core, the audio sample loader and the host/debug port.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   core_*               core request, payload, stall and read data
//   smp_*                sample loader write request and ready
//   host_*               host read/write request, ready, registered read data
//   rf_*                 register file control/data (combinational read)
//   prot_err             sticky error for a granted write to r0
//
// Optional feature: define REGFILE_SCHED_R0_PROTECT_EN to suppress writes
// to r0 and flag them on prot_err. Without it, r0 writes pass through and
// prot_err is tied low.
module regfile_port_sched #(
    parameter int WIDTH    = 32,
    parameter int REGBITS  = 4,
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               core_req,
    input  logic               core_we,
    input  logic [REGBITS-1:0] core_src_addr,
    input  logic [REGBITS-1:0] core_dst_addr,
    input  logic [WIDTH-1:0]   core_wdata,
    output logic               core_stall,
    output logic [WIDTH-1:0]   core_rdata1,
    output logic [WIDTH-1:0]   core_rdata2,
    input  logic               smp_valid,
    input  logic [REGBITS-1:0] smp_addr,
    input  logic [WIDTH-1:0]   smp_data,
    output logic               smp_ready,
    input  logic               host_valid,
    input  logic               host_we,
    input  logic [REGBITS-1:0] host_addr,
    input  logic [WIDTH-1:0]   host_wdata,
    output logic               host_ready,
    output logic               host_rvalid,
    output logic [WIDTH-1:0]   host_rdata,
    output logic               rf_regwrite,
    output logic [REGBITS-1:0] rf_src_addr,
    output logic [REGBITS-1:0] rf_dst_addr,
    output logic [WIDTH-1:0]   rf_data_in,
    input  logic [WIDTH-1:0]   rf_data_out1,
    input  logic [WIDTH-1:0]   rf_data_out2,
    output logic               prot_err
);

    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

    logic              rr_ptr;
    logic [WAIT_W-1:0] wait_smp;
    logic [WAIT_W-1:0] wait_host;

    logic gnt_core;
    logic gnt_smp;
    logic gnt_host;
    logic smp_urgent;
    logic host_urgent;
    logic wr_req;

    // Starvation counter: counts cycles a valid request goes unserved,
    // saturating at MAX_WAIT; any grant or dropped request clears it.
    function automatic logic [WAIT_W-1:0] next_wait(
        input logic              valid,
        input logic              gnt,
        input logic [WAIT_W-1:0] cnt
    );
        if (!valid || gnt)
            return '0;
        else if (cnt == MAX_W)
            return cnt;
        else
            return cnt + WAIT_W'(1);
    endfunction

    assign smp_urgent  = smp_valid  && (wait_smp  == MAX_W);
    assign host_urgent = host_valid && (wait_host == MAX_W);

    always_comb begin
        gnt_core = 1'b0;
        gnt_smp  = 1'b0;
        gnt_host = 1'b0;
        if (reset) begin
            gnt_core = 1'b0;
        end else if (smp_urgent && host_urgent) begin
            gnt_host = rr_ptr;
            gnt_smp  = ~rr_ptr;
        end else if (smp_urgent) begin
            gnt_smp = 1'b1;
        end else if (host_urgent) begin
            gnt_host = 1'b1;
        end else if (core_req) begin
            gnt_core = 1'b1;
        end else if (smp_valid && host_valid) begin
            gnt_host = rr_ptr;
            gnt_smp  = ~rr_ptr;
        end else if (smp_valid) begin
            gnt_smp = 1'b1;
        end else if (host_valid) begin
            gnt_host = 1'b1;
        end
    end

    always_comb begin
        wr_req      = 1'b0;
        rf_src_addr = '0;
        rf_dst_addr = '0;
        rf_data_in  = '0;
        if (gnt_core) begin
            wr_req      = core_we;
            rf_src_addr = core_src_addr;
            rf_dst_addr = core_dst_addr;
            rf_data_in  = core_wdata;
        end else if (gnt_smp) begin
            wr_req      = 1'b1;
            rf_dst_addr = smp_addr;
            rf_data_in  = smp_data;
        end else if (gnt_host) begin
            wr_req      = host_we;
            rf_src_addr = host_addr;
            rf_dst_addr = host_addr;
            rf_data_in  = host_wdata;
        end
    end

`ifdef REGFILE_SCHED_R0_PROTECT_EN
    logic wr_r0;

    // r0 is hardwired zero for the core; block every requester from it.
    assign wr_r0       = wr_req && (rf_dst_addr == '0);
    assign rf_regwrite = wr_req && !wr_r0;

    always_ff @(posedge clk) begin
        if (reset)
            prot_err <= 1'b0;
        else if (wr_r0)
            prot_err <= 1'b1;
    end
`else
    assign rf_regwrite = wr_req;
    assign prot_err    = 1'b0;
`endif

    assign core_stall  = core_req && !gnt_core;
    assign smp_ready   = gnt_smp;
    assign host_ready  = gnt_host;
    assign core_rdata1 = rf_data_out1;
    assign core_rdata2 = rf_data_out2;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= 1'b0;
            wait_smp    <= '0;
            wait_host   <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            if (gnt_smp || gnt_host)
                rr_ptr <= ~rr_ptr;
            wait_smp    <= next_wait(smp_valid, gnt_smp, wait_smp);
            wait_host   <= next_wait(host_valid, gnt_host, wait_host);
            host_rvalid <= gnt_host && !host_we;
            if (gnt_host && !host_we)
                host_rdata <= rf_data_out1;
        end
    end

endmodule

// File: tb/tb_regfile_port_sched.sv
// Testbench for regfile_port_sched: directed vectors, a register file
// model, and a scoreboard monitor for register writes and host reads.
module tb_regfile_port_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req;
    logic        core_we;
    logic [3:0]  core_src_addr;
    logic [3:0]  core_dst_addr;
    logic [31:0] core_wdata;
    logic        core_stall;
    logic [31:0] core_rdata1;
    logic [31:0] core_rdata2;
    logic        smp_valid;
    logic [3:0]  smp_addr;
    logic [31:0] smp_data;
    logic        smp_ready;
    logic        host_valid;
    logic        host_we;
    logic [3:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_ready;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        rf_regwrite;
    logic [3:0]  rf_src_addr;
    logic [3:0]  rf_dst_addr;
    logic [31:0] rf_data_in;
    logic [31:0] rf_data_out1;
    logic [31:0] rf_data_out2;
    logic        prot_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] rq[$];
    wr_t         w;
    logic [31:0] r;
    logic [31:0] mem[16];

    always #5 clk = ~clk;

    regfile_port_sched dut (
        .clk(clk),
        .reset(reset),
        .core_req(core_req),
        .core_we(core_we),
        .core_src_addr(core_src_addr),
        .core_dst_addr(core_dst_addr),
        .core_wdata(core_wdata),
        .core_stall(core_stall),
        .core_rdata1(core_rdata1),
        .core_rdata2(core_rdata2),
        .smp_valid(smp_valid),
        .smp_addr(smp_addr),
        .smp_data(smp_data),
        .smp_ready(smp_ready),
        .host_valid(host_valid),
        .host_we(host_we),
        .host_addr(host_addr),
        .host_wdata(host_wdata),
        .host_ready(host_ready),
        .host_rvalid(host_rvalid),
        .host_rdata(host_rdata),
        .rf_regwrite(rf_regwrite),
        .rf_src_addr(rf_src_addr),
        .rf_dst_addr(rf_dst_addr),
        .rf_data_in(rf_data_in),
        .rf_data_out1(rf_data_out1),
        .rf_data_out2(rf_data_out2),
        .prot_err(prot_err)
    );

    // Register file model: write at the edge, combinational read.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++)
                mem[i] <= '0;
        end else if (rf_regwrite) begin
            mem[rf_dst_addr] <= rf_data_in;
        end
    end

    assign rf_data_out1 = mem[rf_src_addr];
    assign rf_data_out2 = mem[rf_dst_addr];

    // Scoreboard monitor: every write and every host read return must
    // match the next expected entry.
    always @(negedge clk) begin
        if (rf_regwrite) begin
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected: got r%0d=%h required none",
                         rf_dst_addr, rf_data_in);
            end else begin
                w = wq.pop_front();
                if (w.a !== rf_dst_addr || w.d !== rf_data_in) begin
                    failures++;
                    $display("FAIL wr_data: got r%0d=%h required r%0d=%h",
                             rf_dst_addr, rf_data_in, w.a, w.d);
                end
            end
        end
        if (host_rvalid) begin
            checks++;
            if (rq.size() == 0) begin
                failures++;
                $display("FAIL rvalid_unexpected: got %h required none",
                         host_rdata);
            end else begin
                r = rq.pop_front();
                if (host_rdata !== r) begin
                    failures++;
                    $display("FAIL host_rdata: got %h required %h",
                             host_rdata, r);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_req      = 1'b0;
        core_we       = 1'b0;
        core_src_addr = '0;
        core_dst_addr = '0;
        core_wdata    = '0;
        smp_valid     = 1'b0;
        smp_addr      = '0;
        smp_data      = '0;
        host_valid    = 1'b0;
        host_we       = 1'b0;
        host_addr     = '0;
        host_wdata    = '0;
    endtask

    task automatic push_wr(input logic [3:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        wq.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        idle();
        reset = 1'b1;

        // Reset: requests present but nothing granted.
        tick();
        core_req  = 1'b1;
        smp_valid = 1'b1;
        #3;
        chk("rst_stall", 32'(core_stall), 32'd1);
        chk("rst_regwrite", 32'(rf_regwrite), 32'd0);
        chk("rst_smp_ready", 32'(smp_ready), 32'd0);
        tick();
        idle();
        tick();
        reset = 1'b0;
        #3;
        chk("rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_rdata", host_rdata, 32'd0);
        chk("rst_prot", 32'(prot_err), 32'd0);

        // Lone sample write, then host read-back.
        tick();
        smp_valid = 1'b1;
        smp_addr  = 4'd5;
        smp_data  = 32'h0000_1234;
        push_wr(4'd5, 32'h0000_1234);
        #3;
        chk("smp_ready", 32'(smp_ready), 32'd1);
        chk("smp_regwrite", 32'(rf_regwrite), 32'd1);
        chk("smp_dst", 32'(rf_dst_addr), 32'd5);
        tick();
        idle();
        host_valid = 1'b1;
        host_addr  = 4'd5;
        rq.push_back(32'h0000_1234);
        #3;
        chk("hrd_ready", 32'(host_ready), 32'd1);
        tick();
        idle();
        #3;
        chk("hrd_rvalid", 32'(host_rvalid), 32'd1);

        // Core writes r3, then hogs the port while the host waits on r3.
        tick();
        core_req      = 1'b1;
        core_we       = 1'b1;
        core_dst_addr = 4'd3;
        core_wdata    = 32'hA5A5_0003;
        push_wr(4'd3, 32'hA5A5_0003);
        #3;
        chk("core_wr_stall", 32'(core_stall), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            core_we       = 1'b0;
            core_dst_addr = '0;
            core_wdata    = '0;
            host_valid    = 1'b1;
            host_addr     = 4'd3;
            #3;
            chk($sformatf("starve%0d_hready", i), 32'(host_ready), 32'd0);
            chk($sformatf("starve%0d_stall", i), 32'(core_stall), 32'd0);
        end
        tick();
        rq.push_back(32'hA5A5_0003);
        #3;
        chk("urgent_hready", 32'(host_ready), 32'd1);
        chk("urgent_stall", 32'(core_stall), 32'd1);
        tick();
        host_valid = 1'b0;
        #3;
        chk("post_urgent_stall", 32'(core_stall), 32'd0);
        chk("post_urgent_rvalid", 32'(host_rvalid), 32'd1);

        // Single sample to bring the round-robin pointer back to sample.
        tick();
        idle();
        smp_valid = 1'b1;
        smp_addr  = 4'd9;
        smp_data  = 32'h0000_0909;
        push_wr(4'd9, 32'h0000_0909);
        #3;
        chk("rr_fix_ready", 32'(smp_ready), 32'd1);

        // Both low-priority requesters held: sample, host, sample, host.
        tick();
        smp_addr   = 4'd10;
        smp_data   = 32'h0000_1010;
        host_valid = 1'b1;
        host_we    = 1'b1;
        host_addr  = 4'd12;
        host_wdata = 32'h0000_1212;
        push_wr(4'd10, 32'h0000_1010);
        #3;
        chk("rr1_smp", 32'(smp_ready), 32'd1);
        chk("rr1_host", 32'(host_ready), 32'd0);
        tick();
        smp_addr = 4'd11;
        smp_data = 32'h0000_1111;
        push_wr(4'd12, 32'h0000_1212);
        #3;
        chk("rr2_host", 32'(host_ready), 32'd1);
        chk("rr2_smp", 32'(smp_ready), 32'd0);
        tick();
        host_addr  = 4'd13;
        host_wdata = 32'h0000_1313;
        push_wr(4'd11, 32'h0000_1111);
        #3;
        chk("rr3_smp", 32'(smp_ready), 32'd1);
        tick();
        smp_addr = 4'd15;
        smp_data = 32'h0000_1515;
        push_wr(4'd13, 32'h0000_1313);
        #3;
        chk("rr4_host", 32'(host_ready), 32'd1);
        chk("rr4_smp", 32'(smp_ready), 32'd0);
        tick();
        host_valid = 1'b0;
        push_wr(4'd15, 32'h0000_1515);
        #3;
        chk("rr5_smp", 32'(smp_ready), 32'd1);

        // Host write then core read of the same register.
        tick();
        idle();
        host_valid = 1'b1;
        host_we    = 1'b1;
        host_addr  = 4'd7;
        host_wdata = 32'hDEAD_BEEF;
        push_wr(4'd7, 32'hDEAD_BEEF);
        #3;
        chk("hwr_ready", 32'(host_ready), 32'd1);
        tick();
        idle();
        core_req      = 1'b1;
        core_src_addr = 4'd7;
        #3;
        chk("core_rd1", core_rdata1, 32'hDEAD_BEEF);
        chk("core_rd_stall", 32'(core_stall), 32'd0);

        // Reset while a host write is pending: it must never land.
        tick();
        idle();
        reset      = 1'b1;
        host_valid = 1'b1;
        host_we    = 1'b1;
        host_addr  = 4'd8;
        host_wdata = 32'h0000_0088;
        #3;
        chk("rstw_regwrite", 32'(rf_regwrite), 32'd0);
        chk("rstw_ready", 32'(host_ready), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        idle();
        #3;
        chk("rstw_rvalid", 32'(host_rvalid), 32'd0);
        chk("rstw_prot", 32'(prot_err), 32'd0);
        tick();
        smp_valid  = 1'b1;
        smp_addr   = 4'd14;
        smp_data   = 32'h0000_1414;
        host_valid = 1'b1;
        host_addr  = 4'd8;
        push_wr(4'd14, 32'h0000_1414);
        #3;
        chk("rstw_dual_smp", 32'(smp_ready), 32'd1);
        chk("rstw_dual_host", 32'(host_ready), 32'd0);
        tick();
        smp_valid = 1'b0;
        rq.push_back(32'h0000_0000);
        #3;
        chk("rstw_hrd_ready", 32'(host_ready), 32'd1);
        tick();
        idle();

        // Core write to r0.
        tick();
        core_req      = 1'b1;
        core_we       = 1'b1;
        core_dst_addr = 4'd0;
        core_wdata    = 32'h0000_0001;
`ifdef REGFILE_SCHED_R0_PROTECT_EN
        #3;
        chk("r0_regwrite", 32'(rf_regwrite), 32'd0);
        chk("r0_stall", 32'(core_stall), 32'd0);
        chk("r0_prot_same", 32'(prot_err), 32'd0);
        tick();
        idle();
        #3;
        chk("r0_prot_next", 32'(prot_err), 32'd1);
        tick();
        tick();
        #3;
        chk("r0_prot_sticky", 32'(prot_err), 32'd1);
`else
        push_wr(4'd0, 32'h0000_0001);
        #3;
        chk("r0_regwrite", 32'(rf_regwrite), 32'd1);
        chk("r0_stall", 32'(core_stall), 32'd0);
        tick();
        idle();
        #3;
        chk("r0_prot_next", 32'(prot_err), 32'd0);
        tick();
        tick();
        #3;
        chk("r0_prot_later", 32'(prot_err), 32'd0);
`endif

        tick();
        tick();
        #3;
        chk("wq_empty", 32'(wq.size()), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
